// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: aligns capture to VSYNC frame boundaries and drives the
// write port of the RGB444 frame buffer in single-shot or continuous mode.
module cam_capture_ctrl #(
    parameter int AW       = 15,
    parameter int DW       = 12,
    parameter int IMG_SIZE = 19200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_snap,
    input  logic          cmd_cont,
    input  logic          cmd_stop,
    input  logic          vsync,
    input  logic          px_valid,
    input  logic [DW-1:0] px_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          cap_active,
    output logic          img_valid,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          size_err,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [AW:0] IMG_CNT = (AW+1)'(IMG_SIZE);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;          // 1 = continuous, 0 = single
    logic          stop_pend_q, stop_pend_d;
    logic [AW:0]   pix_cnt_q, pix_cnt_d;
    logic          vsync_q;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          serr_q, serr_d;
    logic          sof, eof;

    assign sof = ~vsync & vsync_q;
    assign eof = vsync & ~vsync_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        pix_cnt_d   = pix_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        fcnt_d      = fcnt_q;
        serr_d      = serr_q;
        case (state_q)
            IDLE, HOLD: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (cmd_snap) begin
                    state_d = WAIT_SOF;
                    mode_d  = 1'b0;
                    serr_d  = 1'b0;
                end else if (cmd_cont) begin
                    state_d = WAIT_SOF;
                    mode_d  = 1'b1;
                    serr_d  = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (sof) begin
                    state_d   = CAPTURE;
                    pix_cnt_d = '0;
                end
            end
            CAPTURE: begin
                if (cmd_stop) stop_pend_d = 1'b1;
                if (px_valid) begin
                    if (pix_cnt_q < IMG_CNT) begin
                        we_d      = 1'b1;
                        addr_d    = pix_cnt_q[AW-1:0];
                        data_d    = px_data;
                        pix_cnt_d = pix_cnt_q + (AW+1)'(1);
                    end else begin
                        serr_d = 1'b1;
                    end
                end
                // A pixel arriving in the eof cycle is already counted in pix_cnt_d.
                if (eof) begin
                    done_d      = 1'b1;
                    fcnt_d      = fcnt_q + 8'd1;
                    stop_pend_d = 1'b0;
                    if (pix_cnt_d != IMG_CNT) serr_d = 1'b1;
                    if (stop_pend_q || cmd_stop) state_d = IDLE;
                    else if (mode_q)             state_d = WAIT_SOF;
                    else                         state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            pix_cnt_q   <= '0;
            vsync_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            fcnt_q      <= '0;
            serr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            pix_cnt_q   <= pix_cnt_d;
            vsync_q     <= vsync;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            fcnt_q      <= fcnt_d;
            serr_q      <= serr_d;
        end
    end

    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign cap_active = (state_q == CAPTURE);
    assign img_valid  = (state_q == HOLD);
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign size_err   = serr_q;
    assign state      = state_q;

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-capture sequencer between the camera pixel-assembly datapath and the 160x120 RGB444 dual-port frame buffer. It arms on user commands, aligns capture to camera VSYNC frame boundaries, and generates the write-port strobe, address and data for the buffer. It supports single-shot (freeze) and continuous modes, counts frames, and flags frames whose pixel count is wrong. Everything runs in the single `clk` domain; `vsync` and `px_valid` arrive already synchronised.

Parameters:
AW, 15, frame-buffer address width
DW, 12, pixel width (RGB444)
IMG_SIZE, 19200, pixels per frame (160*120)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cmd_snap  in  1  one-cycle pulse; capture one frame then freeze
cmd_cont  in  1  one-cycle pulse; capture every frame
cmd_stop  in  1  one-cycle pulse; stop capturing
vsync  in  1  synchronised camera VSYNC; high = vertical blanking
px_valid  in  1  one-cycle strobe; assembled pixel available on px_data
px_data  in  DW  assembled RGB444 pixel
ram_we  out  1  frame-buffer write enable
ram_addr  out  AW  frame-buffer write address
ram_data  out  DW  frame-buffer write data
cap_active  out  1  high while in CAPTURE
img_valid  out  1  high in HOLD (frozen complete frame in buffer)
frame_done  out  1  one-cycle pulse at end of each captured frame
frame_cnt  out  8  captured-frame counter, wraps 255->0
size_err  out  1  sticky: last/current frame pixel count != IMG_SIZE
state  out  2  IDLE=0, WAIT_SOF=1, CAPTURE=2, HOLD=3

Behaviour:
- Reset: all outputs 0; state IDLE; mode=single; stop_pend=0; pix_cnt=0; vsync_q=0. With vsync_q=0, a low vsync at reset release produces no false start-of-frame.
- Edge detection:
  - vsync_q <= vsync every cycle.
  - sof = ~vsync & vsync_q (falling edge).
  - eof = vsync & ~vsync_q (rising edge).
- Command priority when several fire in the same cycle: stop > snap > cont.
- IDLE:
  - snap -> WAIT_SOF, mode=single.
  - cont -> WAIT_SOF, mode=continuous.
  - snap or cont also clears size_err.
  - eof and sof are ignored.
- WAIT_SOF:
  - sof -> CAPTURE, pix_cnt=0.
  - stop -> IDLE.
  - px_valid is ignored.
- CAPTURE, pixel writes:
  - On px_valid with pix_cnt<IMG_SIZE: next cycle ram_we=1, ram_addr=pix_cnt, ram_data=px_data (1-cycle latency); then pix_cnt++.
  - On px_valid with pix_cnt==IMG_SIZE: pixel dropped, ram_we stays 0, size_err<=1.
  - ram_we is high only in the cycle after an accepted px_valid.
- CAPTURE, end of frame (eof):
  - frame_done=1 in the next cycle; frame_cnt++.
  - If the final pix_cnt, including a px_valid in the eof cycle (that pixel is written), != IMG_SIZE, then size_err<=1.
  - Next state: single -> HOLD; continuous with stop_pend -> IDLE; continuous otherwise -> WAIT_SOF.
- CAPTURE, stop handling:
  - cmd_stop sets stop_pend; the frame in progress always completes (buffer never left partially overwritten by a stop).
  - In single mode, stop_pend makes the eof transition go to IDLE instead of HOLD.
  - stop_pend is cleared on leaving CAPTURE.
  - snap/cont in CAPTURE are ignored.
- HOLD:
  - img_valid=1, ram_we=0.
  - snap -> WAIT_SOF single; cont -> WAIT_SOF continuous (either clears size_err).
  - stop -> IDLE.
- Fixed-value outputs: ram_addr and ram_data hold their last values when ram_we=0. cap_active = (state==CAPTURE).
- Mid-operation reset: returns to IDLE in one cycle with ram_we=0 and no frame_done. The next capture requires a fresh command plus a genuine falling edge.
- Counters: pix_cnt is AW+1 bits wide and saturates at IMG_SIZE. frame_cnt is modulo 256.

Test Plan:
1. Reset, then cmd_snap. Feed a 160x120 frame (vsync low, 19200 px_valid, vsync high).
   - 19200 writes, addr 0..19199, each data equal to px_data one cycle earlier.
   - frame_done pulses once; frame_cnt=1; state=HOLD; img_valid=1; size_err=0.
   - A second frame then produces 0 writes.
2. cmd_cont over 3 frames, with cmd_stop pulsed mid-frame 2.
   - Frame 2 completes all 19200 writes; frame_cnt=2; state=IDLE.
   - Frame 3 produces no ram_we.
3. Short frame of 19000 pixels under cmd_snap.
   - size_err=1 at frame_done; state HOLD.
   - A subsequent cmd_snap clears size_err.
4. Long frame of 19210 pixels.
   - Exactly 19200 writes; last addr 19199; 10 pixels dropped; size_err=1.
5. Assert rst with vsync low, mid-frame during CAPTURE, then release rst with vsync still low and pulse cmd_snap.
   - Stays in WAIT_SOF until the next falling edge.
   - No writes before that edge; frame_cnt=0 after reset.
6. cmd_snap, cmd_cont and cmd_stop in the same cycle in IDLE -> stays IDLE. cmd_snap and cmd_cont together -> single mode: HOLD after 1 frame.
